// File: rtl/trinity_pkg.sv
// rtl/trinity_pkg.sv - shared types and constants for the trinity tile-link receiver
package trinity_pkg;

    // Default frame start marker
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Receive framer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK,
        ST_DROP
    } rx_state_t;

    // One payload FIFO entry: {last, data}
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } rx_entry_t;

endpackage

// File: rtl/trinity_link_rx_fifo.sv
// rtl/trinity_link_rx_fifo.sv - payload FIFO with speculative write pointer, commit and rewind
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   wr_en, wr_entry    write one entry at the speculative write pointer
//   commit             publish all speculative writes to the reader
//   rewind             discard all speculative writes
//   rd_en              consumer accepts the head entry (ignored when empty)
//   rd_entry, rd_valid head entry and "committed data present"
//   free               entries still writable, measured against the read pointer
module trinity_link_rx_fifo
    import trinity_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  rx_entry_t                wr_entry,
    input  logic                     commit,
    input  logic                     rewind,
    input  logic                     rd_en,
    output rx_entry_t                rd_entry,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    rx_entry_t         mem [DEPTH];
    logic [PW-1:0]     rptr;
    logic [PW-1:0]     wptr_c;
    logic [PW-1:0]     wptr_s;
    logic [PW-1:0]     used;
    logic              full;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign used     = wptr_s - rptr;
    assign full     = (wptr_s[AW] != rptr[AW]) && (wptr_s[AW-1:0] == rptr[AW-1:0]);
    assign free     = full ? '0 : (PW'(DEPTH) - used);
    assign rd_valid = (rptr != wptr_c);
    assign rd_entry = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_s[AW-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr   <= '0;
            wptr_c <= '0;
            wptr_s <= '0;
        end else begin
            if (rewind) begin
                wptr_s <= wptr_c;
            end else if (wr_en) begin
                wptr_s <= wptr_s + 1'b1;
            end
            if (commit) begin
                wptr_c <= wptr_s;
            end
            if (rd_en && rd_valid) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/trinity_link_rx.sv
// rtl/trinity_link_rx.sv - tile-link frame receiver: SYNC, LEN, payload, CHK into a committed FIFO
//
// Ports:
//   sys_clk, sys_rst_n         clock, asynchronous active-low reset
//   uii_link_in[7:0]           link byte sampled every cycle
//   rx_data, rx_last, rx_valid committed payload stream head; rx_ready accepts it
//   err_len, err_chk, err_ovf  one-cycle error pulses
//   rx_busy                    framer not idle
//   rx_frames, rx_errs         saturating statistics, only with TRINITY_LINK_RX_STATS_EN
module trinity_link_rx
    import trinity_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter int         MAX_LEN    = 8,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  uii_link_in,
    output logic [7:0]  rx_data,
    output logic        rx_last,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        err_len,
    output logic        err_chk,
    output logic        err_ovf,
    output logic        rx_busy
`ifdef TRINITY_LINK_RX_STATS_EN
    ,
    output logic [15:0] rx_frames,
    output logic [15:0] rx_errs
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH) + 1;

    rx_state_t     state, state_d;
    logic [7:0]    cnt, cnt_d;
    logic [7:0]    chk, chk_d;
    logic          wr_en, commit, rewind;
    rx_entry_t     wr_entry, head;
    logic          head_valid;
    logic [PW-1:0] fifo_free;
    logic          len_err_d, chk_err_d, ovf_err_d;

    trinity_link_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .wr_en    (wr_en),
        .wr_entry (wr_entry),
        .commit   (commit),
        .rewind   (rewind),
        .rd_en    (rx_ready),
        .rd_entry (head),
        .rd_valid (head_valid),
        .free     (fifo_free)
    );

    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        chk_d         = chk;
        wr_en         = 1'b0;
        wr_entry.last = (cnt == 8'd1);
        wr_entry.data = uii_link_in;
        commit        = 1'b0;
        rewind        = 1'b0;
        len_err_d     = 1'b0;
        chk_err_d     = 1'b0;
        ovf_err_d     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (uii_link_in == SYNC_BYTE) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (uii_link_in == 8'd0 || uii_link_in > 8'(MAX_LEN)) begin
                    len_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    chk_d = uii_link_in;
                    // A read in this same cycle is deliberately not credited
                    if ({1'b0, uii_link_in} > 9'(fifo_free)) begin
                        ovf_err_d = 1'b1;
                        cnt_d     = uii_link_in + 8'd1;   // payload plus CHK
                        state_d   = ST_DROP;
                    end else begin
                        cnt_d   = uii_link_in;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                wr_en = 1'b1;
                chk_d = chk ^ uii_link_in;
                cnt_d = cnt - 8'd1;
                if (cnt == 8'd1) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // Always back to IDLE: a SYNC_BYTE here never opens a frame
                if (uii_link_in == chk) begin
                    commit = 1'b1;
                end else begin
                    rewind    = 1'b1;
                    chk_err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            ST_DROP: begin
                cnt_d = cnt - 8'd1;
                if (cnt == 8'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            chk     <= '0;
            err_len <= 1'b0;
            err_chk <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            chk     <= chk_d;
            err_len <= len_err_d;
            err_chk <= chk_err_d;
            err_ovf <= ovf_err_d;
        end
    end

    assign rx_busy  = (state != ST_IDLE);
    assign rx_valid = head_valid;
    // Storage is not reset, so the head is masked until committed data exists
    assign rx_data  = head_valid ? head.data : 8'h00;
    assign rx_last  = head_valid ? head.last : 1'b0;

`ifdef TRINITY_LINK_RX_STATS_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_frames <= '0;
            rx_errs   <= '0;
        end else begin
            if (commit && rx_frames != 16'hFFFF) begin
                rx_frames <= rx_frames + 16'd1;
            end
            if ((len_err_d || chk_err_d || ovf_err_d) && rx_errs != 16'hFFFF) begin
                rx_errs <= rx_errs + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_trinity_link_rx.sv
// tb/tb_trinity_link_rx.sv - randomized frame-level checker for trinity_link_rx
module tb_trinity_link_rx;
    import trinity_pkg::*;

    localparam int DEPTH = 16;
    localparam int MAXL  = 8;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  uii_link_in = 8'h00;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_last, rx_valid, err_len, err_chk, err_ovf, rx_busy;
`ifdef TRINITY_LINK_RX_STATS_EN
    logic [15:0] rx_frames, rx_errs;
`endif

    trinity_link_rx #(
        .FIFO_DEPTH (DEPTH),
        .MAX_LEN    (MAXL),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .uii_link_in (uii_link_in),
        .rx_data     (rx_data),
        .rx_last     (rx_last),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .err_len     (err_len),
        .err_chk     (err_chk),
        .err_ovf     (err_ovf),
        .rx_busy     (rx_busy)
`ifdef TRINITY_LINK_RX_STATS_EN
        ,
        .rx_frames   (rx_frames),
        .rx_errs     (rx_errs)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int failures = 0;

    // Reference model state: committed-but-unread bytes and expected event counts
    logic [8:0] exp_q[$];
    logic [7:0] pl_q[$];
    int n_len = 0, n_chk = 0, n_ovf = 0, n_good = 0;
    int seen_len = 0, seen_chk = 0, seen_ovf = 0;
    int popped = 0;
    int rmode = 0;
    bit tog = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] idle_byte();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        return b;
    endfunction

    function automatic logic [7:0] data_byte();
        return (($urandom % 8) == 0) ? 8'hA5 : 8'($urandom);
    endfunction

    // One link cycle, entered and left at a falling edge
    task automatic step(input logic [7:0] b);
        uii_link_in = b;
        case (rmode)
            0: rx_ready = 1'b1;
            1: rx_ready = 1'b0;
            2: begin tog = ~tog; rx_ready = tog; end
            default: rx_ready = (($urandom % 4) != 0);
        endcase
        check_eq("valid", rx_valid, (exp_q.size() != 0));
        if (rx_valid && exp_q.size() != 0) begin
            check_eq("head", {rx_last, rx_data}, exp_q[0]);
            if (rx_ready) begin
                void'(exp_q.pop_front());
                popped++;
            end
        end
        @(posedge sys_clk);
        @(negedge sys_clk);
        seen_len += int'(err_len);
        seen_chk += int'(err_chk);
        seen_ovf += int'(err_ovf);
    endtask

    task automatic fill_random(input int len);
        pl_q.delete();
        for (int i = 0; i < len; i++) pl_q.push_back(data_byte());
    endtask

    // Send one frame built from pl_q; bad=1 corrupts the checksum
    task automatic send_frame(input int len, input bit bad);
        logic [7:0] c;
        int fr;
        step(8'hA5);
        check_eq("busy_after_sync", rx_busy, 1);
        fr = DEPTH - exp_q.size();
        step(8'(len));
        if (len == 0 || len > MAXL) begin
            n_len++;
            check_eq("busy_after_badlen", rx_busy, 0);
            return;
        end
        if (fr < len) begin
            n_ovf++;
            for (int i = 0; i <= len; i++) step(data_byte());
            check_eq("busy_after_drop", rx_busy, 0);
            return;
        end
        c = 8'(len);
        for (int i = 0; i < len; i++) begin
            c ^= pl_q[i];
            step(pl_q[i]);
        end
        if (bad) c ^= 8'($urandom_range(1, 255));
        step(c);
        check_eq("busy_after_chk", rx_busy, 0);
        if (bad) begin
            n_chk++;
        end else begin
            n_good++;
            for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), pl_q[i]});
        end
    endtask

    task automatic drain_and_check(input string tag);
        int budget;
        rmode = 0;
        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            step(idle_byte());
            budget++;
        end
        step(idle_byte());
        check_eq({tag, "_drained"}, exp_q.size(), 0);
        check_eq({tag, "_err_len"}, seen_len, n_len);
        check_eq({tag, "_err_chk"}, seen_chk, n_chk);
        check_eq({tag, "_err_ovf"}, seen_ovf, n_ovf);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, rx_valid, 0);
        check_eq({tag, "_data"}, rx_data, 8'h00);
        check_eq({tag, "_last"}, rx_last, 0);
        check_eq({tag, "_busy"}, rx_busy, 0);
        check_eq({tag, "_errs"}, {err_len, err_chk, err_ovf}, 3'b000);
    endtask

    initial begin
        int p0, ovf0;
        repeat (2) @(negedge sys_clk);
        check_reset_outputs("reset");
        sys_rst_n = 1'b1;
        rmode = 0;
        step(idle_byte());

        // Three-byte good frame with ready held high
        pl_q = '{8'h11, 8'h22, 8'h33};
        send_frame(3, 1'b0);
        drain_and_check("good3");

        // Bad checksum: nothing may become visible
        step(8'hA5); step(8'h02); step(8'h10); step(8'h20); step(8'hFF);
        n_chk++;
        drain_and_check("badchk");

        // SYNC as the (bad) CHK byte must not open a frame; 01,77,76 would be a good frame
        step(8'hA5); step(8'h01); step(8'h00); step(8'hA5);
        n_chk++;
        step(8'h01); step(8'h77); step(8'h76);
        drain_and_check("sync_in_check");

        // Illegal lengths
        send_frame(0, 1'b0);
        send_frame(9, 1'b0);
        drain_and_check("badlen");

        // Overflow with the consumer stalled, then recovery
        ovf0 = n_ovf;
        rmode = 1;
        fill_random(8); send_frame(8, 1'b0);
        fill_random(8); send_frame(8, 1'b0);
        fill_random(1); send_frame(1, 1'b0);
        check_eq("ovf_modelled", n_ovf - ovf0, 1);
        rmode = 0;
        fill_random(2); send_frame(2, 1'b0);
        drain_and_check("overflow");

        // Reset in the middle of a payload
        step(8'hA5); step(8'h04); step(8'h12); step(8'h34);
        sys_rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        @(negedge sys_clk);
        check_reset_outputs("midreset_hold");
        sys_rst_n = 1'b1;
        step(idle_byte());
`ifdef TRINITY_LINK_RX_STATS_EN
        check_eq("stats_reset_frames", rx_frames, 0);
        check_eq("stats_reset_errs", rx_errs, 0);
`endif
        n_len = 0; n_chk = 0; n_ovf = 0; n_good = 0;
        seen_len = 0; seen_chk = 0; seen_ovf = 0;
        fill_random(4); send_frame(4, 1'b0);
        drain_and_check("after_reset");

        // Twenty back-to-back one-byte frames with ready toggling
        p0 = popped;
        rmode = 2;
        for (int i = 0; i < 20; i++) begin
            fill_random(1);
            send_frame(1, 1'b0);
        end
        drain_and_check("toggle20");
        check_eq("toggle20_count", popped - p0, 20);

        // Randomized traffic
        for (int f = 0; f < 150; f++) begin
            int len;
            if ((f % 10) == 0) rmode = int'($urandom % 4);
            len = (($urandom % 8) == 0) ? ((($urandom % 2) == 0) ? 0 : int'($urandom_range(9, 12)))
                                        : int'($urandom_range(1, MAXL));
            fill_random(len);
            send_frame(len, (($urandom % 5) == 0));
            repeat ($urandom % 3) step(idle_byte());
        end
        drain_and_check("random");
`ifdef TRINITY_LINK_RX_STATS_EN
        check_eq("stats_frames", rx_frames, 16'(n_good));
        check_eq("stats_errs", rx_errs, 16'(n_len + n_chk + n_ovf));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
